conv_row_feeder: RTL and testbench

Raster-to-column feeder placed directly upstream of the 5x5 convolution window. It accepts one feature-map pixel per cycle over a valid/ready handshake and keeps the four previous image rows in on-chip line buffers. Each cycle it presents the 5-pixel vertical column for the current position on `in1`..`in5` together with the window-latch enable `en`. It flags exactly those cycles in which the downstream window holds a complete, in-bounds 5x5 patch.

---
 rtl/conv_row_feeder.sv | 158 +++++++++++++++
 tb/tb_conv_row_feeder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_row_feeder.sv
// Raster-to-column feeder for a 5x5 convolution window: four line buffers supply rows r-4..r-1.
// Optional per-frame window counter enabled by defining CONV_FEEDER_WINCNT_EN.
module conv_row_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BIT_WIDTH-1:0] s_data,
  output logic [BIT_WIDTH-1:0] in1,
  output logic [BIT_WIDTH-1:0] in2,
  output logic [BIT_WIDTH-1:0] in3,
  output logic [BIT_WIDTH-1:0] in4,
  output logic [BIT_WIDTH-1:0] in5,
  output logic                 en,
  output logic                 win_valid,
  output logic [15:0]          win_row,
  output logic [15:0]          win_col,
  output logic                 done,
  output logic [15:0]          win_count
);

  localparam int          IDX_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [15:0]               row_reg, row_next;
  logic [15:0]               col_reg, col_next;
  logic                      win_valid_reg;
  logic [15:0]               win_row_reg, win_col_reg;
  logic [IDX_W-1:0]          col_idx;
  logic [3:0][BIT_WIDTH-1:0] tap;
  logic                      accept;
  logic                      win_hit;

  assign col_idx = col_reg[IDX_W-1:0];
  assign en      = s_valid & s_ready;
  assign accept  = en;
  // Only columns 4.. of rows 4.. close a full in-bounds patch, so no window spans a row wrap.
  assign win_hit = accept && (row_reg >= 16'd4) && (col_reg >= 16'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    s_ready    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          row_next   = '0;
          col_next   = '0;
        end
      end
      RUN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (col_reg == COL_LAST) begin
            col_next = '0;
            row_next = row_reg + 16'd1;
            if (row_reg == ROW_LAST) state_next = DONE;
          end else begin
            col_next = col_reg + 16'd1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line buffer gi holds row r-4+gi at each column; an accept shifts the column up by one row.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lb
      logic [BIT_WIDTH-1:0] mem [IMG_W];
      logic [BIT_WIDTH-1:0] shift_in;
      if (gi == 3) begin : g_top
        assign shift_in = s_data;
      end else begin : g_mid
        assign shift_in = tap[gi+1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < IMG_W; i++) mem[i] <= '0;
        end else if (accept) begin
          mem[col_idx] <= shift_in;
        end
      end
      assign tap[gi] = mem[col_idx];
    end
  endgenerate

  assign in1 = tap[0];
  assign in2 = tap[1];
  assign in3 = tap[2];
  assign in4 = tap[3];
  assign in5 = s_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
    end else begin
      win_valid_reg <= win_hit;
      if (win_hit) begin
        win_row_reg <= row_reg - 16'd4;
        win_col_reg <= col_reg - 16'd4;
      end
    end
  end

  assign win_valid = win_valid_reg;
  assign win_row   = win_row_reg;
  assign win_col   = win_col_reg;

`ifdef CONV_FEEDER_WINCNT_EN
  // Counts on the same edge that raises win_valid, so the final total is visible alongside done.
  logic [15:0] win_count_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      win_count_reg <= '0;
    end else if (win_hit && win_count_reg != 16'hFFFF) begin
      win_count_reg <= win_count_reg + 16'd1;
    end
  end
  assign win_count = win_count_reg;
`else
  assign win_count = '0;
`endif

endmodule

// File: tb/tb_conv_row_feeder.sv
// Scoreboard bench for conv_row_feeder: a frame-level reference model queues expected
// columns, windows and done pulses; a negedge monitor pops and compares them.
module tb_conv_row_feeder;

  localparam int BW   = 8;
  localparam int W    = 32;
  localparam int H    = 32;
  localparam int NWIN = (H - 4) * (W - 4);
`ifdef CONV_FEEDER_WINCNT_EN
  localparam bit WCNT = 1'b1;
`else
  localparam bit WCNT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic [BW-1:0] in1, in2, in3, in4, in5;
  logic          en;
  logic          win_valid;
  logic [15:0]   win_row, win_col;
  logic          done;
  logic [15:0]   win_count;

  conv_row_feeder #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .en(en), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .done(done), .win_count(win_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          chk;
    logic [4:0][BW-1:0] v;
  } col_t;

  typedef struct {
    int r;
    int c;
    int cyc;
    int idx;
  } win_t;

  bit   en_q[$];
  col_t in_q[$];
  win_t win_q[$];
  int   done_q[$];

  int errors = 0;
  int checks = 0;
  int win_seen = 0;
  int done_seen = 0;

  logic [BW-1:0] img [H][W];
  int m_state = 0;  // 0 idle, 1 run, 2 done
  int mr = 0, mc = 0, m_wins = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus, issued just after a rising edge; the model decides acceptance.
  task automatic step(input bit v, input bit st);
    bit   acc;
    col_t e;
    win_t w;
    acc     = v && (m_state == 1);
    s_valid = v;
    start   = st;
    s_data  = (m_state == 1) ? img[mr][mc] : BW'($urandom);
    en_q.push_back(acc);
    if (acc) begin
      e.chk = (mr >= 4);
      e.v   = '0;
      if (mr >= 4) for (int k = 0; k < 5; k++) e.v[k] = img[mr - 4 + k][mc];
      in_q.push_back(e);
      if (mr >= 4 && mc >= 4) begin
        m_wins++;
        w.r = mr - 4; w.c = mc - 4; w.cyc = cyc + 1; w.idx = m_wins;
        win_q.push_back(w);
      end
      if (mr == H - 1 && mc == W - 1) begin
        done_q.push_back(cyc + 1);
        m_state = 2;
      end else if (mc == W - 1) begin
        mc = 0;
        mr++;
      end else begin
        mc++;
      end
    end else if (m_state == 0 && st) begin
      m_state = 1; mr = 0; mc = 0; m_wins = 0;
    end else if (m_state == 2) begin
      m_state = 0;
    end
    @(posedge clk);
    #2;
  endtask

  // Start pulse (with s_valid high to show IDLE refuses data), then pixels until the frame
  // ends or stop_at accepts; returns with the DONE cycle already stepped when the frame ends.
  task automatic run_frame(input int pct, input int stop_at);
    int base;
    int dbase;
    int guard;
    base  = win_seen;
    dbase = done_seen;
    step(1'b1, 1'b1);
    check("wcnt_after_start", win_count, 0);
    guard = 0;
    while (m_state == 1 && (mr * W + mc) < stop_at && guard < 20000) begin
      step($urandom_range(0, 99) < pct, $urandom_range(0, 63) == 0);
      guard++;
    end
    if (m_state == 2) begin
      step(1'b1, 1'b1);
      check("frame_windows", win_seen - base, NWIN);
      check("frame_done", done_seen - dbase, 1);
    end
  endtask

  task automatic fill(input bit pattern);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pattern ? BW'((r * 32 + c) % 256) : BW'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_en"}, en, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_win_row"}, win_row, 0);
    check({tag, "_win_col"}, win_col, 0);
    check({tag, "_win_count"}, win_count, 0);
    check({tag, "_in1"}, in1, 0);
    check({tag, "_in2"}, in2, 0);
    check({tag, "_in3"}, in3, 0);
    check({tag, "_in4"}, in4, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an accept, window or done.
  initial begin
    col_t e;
    win_t w;
    int   dc;
    bit   ee;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (en_q.size() > 0) begin
        ee = en_q.pop_front();
        check("en", en, ee);
      end
      if (en) begin
        if (in_q.size() == 0) check("unexpected_accept", 1, 0);
        else begin
          e = in_q.pop_front();
          if (e.chk) begin
            check("in1", in1, e.v[0]);
            check("in2", in2, e.v[1]);
            check("in3", in3, e.v[2]);
            check("in4", in4, e.v[3]);
            check("in5", in5, e.v[4]);
          end
        end
      end
      if (win_valid) begin
        win_seen++;
        if (win_q.size() == 0) check("unexpected_win", 1, 0);
        else begin
          w = win_q.pop_front();
          check("win_row", win_row, w.r);
          check("win_col", win_col, w.c);
          check("win_cycle", cyc, w.cyc);
          check("win_count", win_count, WCNT ? w.idx : 0);
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          dc = done_q.pop_front();
          check("done_cycle", cyc, dc);
          check("done_win_count", win_count, WCNT ? NWIN : 0);
          check("done_last_win", {31'd0, win_valid}, 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b1; s_data = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Ramp frame, continuous valid, then the same frame with 50% bubbles.
    fill(1'b1);
    run_frame(100, W * H);
    run_frame(50, W * H);

    // Reset mid-frame after 500 accepts, then a full frame of fresh data.
    run_frame(100, 500);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    s_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    en_q.delete(); in_q.delete(); win_q.delete(); done_q.delete();
    m_state = 0; mr = 0; mc = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    fill(1'b0);
    run_frame(50, W * H);

    // Back-to-back frame with new random data at minimum spacing.
    fill(1'b0);
    run_frame(70, W * H);

    repeat (4) step(1'b0, 1'b0);
    check("en_q_left", en_q.size(), 0);
    check("in_q_left", in_q.size(), 0);
    check("win_q_left", win_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
